// File: rtl/text_pkg.sv
// text_pkg: shared constants and FSM state encoding for the text flush scanner.
package text_pkg;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_CHAR_H = 10;
    localparam int COLOUR_W = 6;
    localparam int COORD_W = 8;
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
endpackage

// File: rtl/text_cursor_counter.sv
// text_cursor_counter: nested col/row/char counters for the pixel sweep, with a last-pixel flag.
module text_cursor_counter import text_pkg::*; #(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CHAR_H = DEF_CHAR_H,
    parameter int IDX_W = 4,
    localparam int COL_W = $clog2(CHAR_W),
    localparam int ROW_W = $clog2(CHAR_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic             stall,
    input  logic [IDX_W:0]   count,
    output logic [IDX_W-1:0] idx,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             last
);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(CHAR_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(CHAR_H - 1);
    logic col_end, row_end, step;
    assign col_end = col == COL_MAX;
    assign row_end = row == ROW_MAX;
    assign step = advance && !stall;
    assign last = col_end && row_end && ({1'b0, idx} == count - 1'b1);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
            col <= '0;
            row <= '0;
        end else if (clear) begin
            idx <= '0;
            col <= '0;
            row <= '0;
        end else if (step) begin
            col <= col_end ? '0 : col + 1'b1;
            if (col_end) row <= row_end ? '0 : row + 1'b1;
            if (col_end && row_end) idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/text_flush_scanner.sv
// text_flush_scanner: sweeps character cells pixel by pixel and emits registered plot writes.
// Define TEXT_FLUSH_BG_EN to plot every swept pixel, using BG_COLOUR where the glyph is off.
module text_flush_scanner import text_pkg::*; #(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int CHAR_H = DEF_CHAR_H,
    parameter int MAX_CHARS = 16,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 6'b000000,
    localparam int IDX_W = $clog2(MAX_CHARS),
    localparam int COL_W = $clog2(CHAR_W),
    localparam int ROW_W = $clog2(CHAR_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COORD_W-1:0]  origin_x,
    input  logic [COORD_W-1:0]  origin_y,
    input  logic [IDX_W:0]      char_count,
    output logic [IDX_W-1:0]    char_index,
    output logic [COORD_W-1:0]  cell_x,
    output logic [COORD_W-1:0]  cell_y,
    output logic [COORD_W-1:0]  flush_x,
    output logic [COORD_W-1:0]  flush_y,
    input  logic [COLOUR_W-1:0] glyph_colour,
    input  logic                glyph_enable,
    output logic                plot,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    input  logic                plot_ready,
    output logic                busy,
    output logic                done
);
    state_t state, next;
    logic [COORD_W-1:0] origin_x_q, origin_y_q;
    logic [IDX_W:0] count_q, count_in;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic last, stall, load, go, pix_plot;
    logic [COLOUR_W-1:0] pix_colour;
    assign count_in = char_count > (IDX_W+1)'(MAX_CHARS) ? (IDX_W+1)'(MAX_CHARS) : char_count;
    assign go = state == IDLE && start && count_in != '0;
    assign stall = plot && !plot_ready;
    assign load = state == SCAN && !stall;
    assign busy = state == SCAN || state == DRAIN;
    assign done = state == DONE;
    assign cell_x = origin_x_q + COORD_W'(int'(char_index) * CHAR_W);
    assign cell_y = origin_y_q;
    assign flush_x = cell_x + COORD_W'(col);
    assign flush_y = cell_y + COORD_W'(row);
    // Without the background feature a disabled pixel is never plotted, so its colour is don't-care.
    assign pix_colour = glyph_enable ? glyph_colour : BG_COLOUR;
`ifdef TEXT_FLUSH_BG_EN
    assign pix_plot = 1'b1;
`else
    assign pix_plot = glyph_enable;
`endif
    text_cursor_counter #(.CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .IDX_W(IDX_W)) u_cursor (
        .clk(clk),
        .reset(reset),
        .clear(go),
        .advance(state == SCAN && !last),
        .stall(stall),
        .count(count_q),
        .idx(char_index),
        .col(col),
        .row(row),
        .last(last)
    );
    // The last pixel always passes through DRAIN so its plot gets a visible cycle before done.
    always_comb begin
        next = state;
        if (state == IDLE && start) next = count_in != '0 ? SCAN : DONE;
        if (state == SCAN && load && last) next = DRAIN;
        if (state == DRAIN && !stall) next = DONE;
        if (state == DONE) next = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            origin_x_q <= '0;
            origin_y_q <= '0;
            count_q <= '0;
            plot <= 1'b0;
            plot_x <= '0;
            plot_y <= '0;
            plot_colour <= '0;
        end else begin
            state <= next;
            if (go) begin
                origin_x_q <= origin_x;
                origin_y_q <= origin_y;
                count_q <= count_in;
            end
            if (load) begin
                plot <= pix_plot;
                plot_x <= flush_x;
                plot_y <= flush_y;
                plot_colour <= pix_colour;
            end else if (!stall) begin
                plot <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_text_flush_scanner.sv
// tb_text_flush_scanner: directed self-checking bench for text_flush_scanner.
module tb_text_flush_scanner;
`ifdef TEXT_FLUSH_BG_EN
    localparam bit BG = 1'b1;
`else
    localparam bit BG = 1'b0;
`endif
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset, start, glyph_enable, plot, plot_ready, busy, done;
    logic [7:0] origin_x, origin_y, cell_x, cell_y, flush_x, flush_y, plot_x, plot_y;
    logic [4:0] char_count;
    logic [3:0] char_index;
    logic [5:0] glyph_colour, plot_colour;
    int checks = 0, errors = 0;
    int mode, cyc, acc, first_cyc, done_cyc, hold_left, restart_at, glyph_col;
    logic [7:0] fx_log [2048];
    logic [7:0] cx_log [2048];
    logic [7:0] px_log [2048];
    logic [5:0] pc_log [2048];
    logic [3:0] ix_log [2048];
    logic       pl_log [2048];

    text_flush_scanner #(.BG_COLOUR(6'h01)) dut (
        .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
        .char_count(char_count), .char_index(char_index), .cell_x(cell_x), .cell_y(cell_y),
        .flush_x(flush_x), .flush_y(flush_y), .glyph_colour(glyph_colour),
        .glyph_enable(glyph_enable), .plot(plot), .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot_ready(plot_ready), .busy(busy), .done(done)
    );

    // Decoder stand-in: mode 0 blank, mode 1 one lit pixel at (12,20), mode 2 everything lit.
    always_comb begin
        glyph_enable = mode == 2 || (mode == 1 && flush_x == 8'd12 && flush_y == 8'd20);
        glyph_colour = mode == 2 ? flush_x[5:0] : 6'h3F;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic [4:0] n, input int m);
        mode = m;
        origin_x = x;
        origin_y = y;
        char_count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        acc = 0;
        first_cyc = -1;
        done_cyc = -1;
        glyph_col = -1;
    endtask

    task automatic run(input int limit);
        while (done_cyc < 0 && cyc <= limit) begin
            start = cyc == restart_at;
            if (start) origin_x = 8'd99;
            plot_ready = !(plot && hold_left > 0);
            if (plot && hold_left > 0) hold_left--;
            if (plot && first_cyc < 0) first_cyc = cyc;
            if (plot && plot_ready) acc++;
            if (plot && plot_x == 8'd12 && plot_y == 8'd20) glyph_col = int'(plot_colour);
            if (cyc < 2048) begin
                fx_log[cyc] = flush_x;
                cx_log[cyc] = cell_x;
                px_log[cyc] = plot_x;
                pc_log[cyc] = plot_colour;
                ix_log[cyc] = char_index;
                pl_log[cyc] = plot;
            end
            if (done) done_cyc = cyc;
            else begin
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        plot_ready = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        origin_x = '0;
        origin_y = '0;
        char_count = '0;
        plot_ready = 1'b1;
        mode = 0;
        hold_left = 0;
        restart_at = -1;
        #12;
        check("rst_flags", {plot, busy, done}, 3'b000);
        check("rst_coords", {cell_x, cell_y, flush_x, flush_y}, 32'h0);
        check("rst_plot", {plot_x, plot_y, plot_colour, char_index}, 26'h0);
        tick();
        reset = 1'b0;
        tick();

        launch(8'd10, 8'd20, 5'd1, 1);
        run(200);
        check("single_plots", acc, BG ? 80 : 1);
        check("single_first_cyc", first_cyc, BG ? 2 : 4);
        check("single_x", px_log[first_cyc & 2047], BG ? 10 : 12);
        check("single_colour", pc_log[first_cyc & 2047], BG ? 6'h01 : 6'h3F);
        check("single_glyph_colour", glyph_col, 32'h3F);
        check("single_done_cyc", done_cyc, 82);
        check("done_flags", {plot, busy}, 2'b00);
        tick();
        check("after_done", {done, busy, plot}, 3'b000);

        launch(8'd0, 8'd0, 5'd3, 2);
        run(400);
        check("multi_cell0", cx_log[1], 8'd0);
        check("multi_cell1", cx_log[81], 8'd8);
        check("multi_cell2", cx_log[161], 8'd16);
        check("multi_index", {ix_log[1], ix_log[81], ix_log[161]}, 12'h012);
        check("multi_plots", acc, 240);
        check("multi_done_cyc", done_cyc, 242);
        tick();

        hold_left = 5;
        launch(8'd10, 8'd20, 5'd1, 1);
        run(200);
        check("bp_first_cyc", first_cyc, BG ? 2 : 4);
        check("bp_plot_held", {pl_log[(first_cyc + 4) & 2047], px_log[(first_cyc + 4) & 2047]},
              {1'b1, BG ? 8'd10 : 8'd12});
        check("bp_colour_held", pc_log[(first_cyc + 4) & 2047], BG ? 6'h01 : 6'h3F);
        check("bp_cursor_held", fx_log[(first_cyc + 4) & 2047], BG ? 8'd11 : 8'd13);
        check("bp_plots", acc, BG ? 80 : 1);
        check("bp_done_cyc", done_cyc, 87);
        tick();

        launch(8'd250, 8'd0, 5'd2, 2);
        run(300);
        check("wrap_fx255", fx_log[6], 8'd255);
        check("wrap_fx0", fx_log[7], 8'd0);
        check("wrap_fx1", fx_log[8], 8'd1);
        check("wrap_cell1", cx_log[81], 8'd2);
        check("wrap_first_plot", {px_log[2], pc_log[2]}, {8'd250, 6'h3A});
        check("wrap_done_cyc", done_cyc, 162);
        tick();

        launch(8'd0, 8'd0, 5'd0, 2);
        run(10);
        check("zero_done_cyc", done_cyc, 1);
        check("zero_plots", acc, 0);
        tick();

        launch(8'd0, 8'd0, 5'd20, 0);
        run(1400);
        check("clamp_done_cyc", done_cyc, 1282);
        check("clamp_plots", acc, BG ? 1280 : 0);
        tick();

        restart_at = 10;
        launch(8'd10, 8'd20, 5'd1, 1);
        run(200);
        restart_at = -1;
        check("restart_cell", cx_log[20], 8'd10);
        check("restart_done_cyc", done_cyc, 82);
        tick();

        launch(8'd30, 8'd40, 5'd1, 2);
        run(41);
        check("abort_no_done", done_cyc, -1);
        #2 reset = 1'b1;
        #1;
        check("abort_flags", {plot, busy, done}, 3'b000);
        check("abort_coords", {cell_x, cell_y, flush_x, flush_y}, 32'h0);
        check("abort_plot", {plot_x, plot_y, plot_colour, char_index}, 26'h0);
        tick();
        reset = 1'b0;
        tick();
        launch(8'd10, 8'd20, 5'd1, 1);
        run(200);
        check("fresh_plots", acc, BG ? 80 : 1);
        check("fresh_done_cyc", done_cyc, 82);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
